// File: rtl/ni_inject.sv
// NoC network-interface injection stage: PE flits are buffered in a FIFO and
// optionally timestamped. They are then forwarded to the router under credit-based flow control.
module ni_inject #(
  parameter int unsigned FLIT_W  = 38,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 8,
  parameter bit          STAMP   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        i_data,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  output logic [FLIT_W-1:0]        o_flit,
  output logic                     o_flit_valid,
  input  logic                     i_credit,
  output logic [31:0]              o_sent_count,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_credit_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CREDITS + 1);
  // The valid and vc bits are forced on output, so only tail/dest/payload are stored
  localparam int unsigned SW = FLIT_W - 2;

  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] credits;
  logic [31:0]   cyc;
  logic          push;
  logic          pop;
  logic [SW-1:0] wr_word;
  logic [SW-1:0] head;
  logic          unused_bits;

  assign unused_bits  = ^{i_data[FLIT_W-1], i_data[32]};
  assign o_data_ready = !rst && (level != LW'(DEPTH));
  assign push         = i_data_valid && o_data_ready;
  // A credit arriving this cycle may enable a pop at the same edge
  assign pop          = (level != '0) && ((credits != '0) || i_credit);
  assign head         = mem[rd_ptr];
  assign o_level      = level;

  always_comb begin
    wr_word = {i_data[FLIT_W-2:33], i_data[31:0]};
    if (STAMP) wr_word[31:0] = cyc;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      credits      <= CW'(CREDITS);
      cyc          <= '0;
      o_flit       <= '0;
      o_flit_valid <= 1'b0;
      o_sent_count <= '0;
      o_credit_err <= 1'b0;
    end else begin
      cyc <= cyc + 32'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (pop) begin
        o_flit       <= {1'b1, head[SW-1:32], 1'b0, head[31:0]};
        o_flit_valid <= 1'b1;
        o_sent_count <= o_sent_count + 32'd1;
      end else begin
        o_flit_valid <= 1'b0;
      end

      if (pop && !i_credit) begin
        credits <= credits - CW'(1);
      end else if (i_credit && !pop) begin
        if (credits == CW'(CREDITS)) o_credit_err <= 1'b1;
        else                         credits      <= credits + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ni_inject.sv
// Directed bench for ni_inject: latency, stamping, credit starvation, FIFO full,
// streaming, credit overflow and mid-run reset.
module tb_ni_inject;

  logic        clk;
  logic        rst;
  logic [37:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [37:0] o_flit;
  logic        o_flit_valid;
  logic        i_credit;
  logic [31:0] o_sent_count;
  logic [2:0]  o_level;
  logic        o_credit_err;

  int unsigned vectors;
  int unsigned miscompares;

  ni_inject #(.FLIT_W(38), .DEPTH(4), .CREDITS(8), .STAMP(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_flit       (o_flit),
    .o_flit_valid (o_flit_valid),
    .i_credit     (i_credit),
    .o_sent_count (o_sent_count),
    .o_level      (o_level),
    .o_credit_err (o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Input flit: valid bit low and vc high so output forcing is visible
  function automatic logic [37:0] fin(input logic [2:0] dest, input logic tail);
    return {1'b0, tail, dest, 1'b1, 32'hFFFF_FFFF};
  endfunction

  function automatic logic [37:0] fout(input logic [2:0] dest, input logic tail,
                                        input logic [31:0] stamp);
    return {1'b1, tail, dest, 1'b0, stamp};
  endfunction

  logic [37:0] order_exp [4];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_credit     = 1'b0;
    #1;
    chk("ready_in_reset", o_data_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_flit", o_flit, 0);
    chk("rst_valid", o_flit_valid, 0);
    chk("rst_sent", o_sent_count, 0);
    chk("rst_level", o_level, 0);
    chk("rst_err", o_credit_err, 0);
    chk("rst_ready", o_data_ready, 1);
    chk("rst_credits", dut.credits, 8);

    // Single flit accepted when the cycle counter reads 10
    repeat (10) step();
    i_data = 38'h3A_DEAD_BEEF;
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
    chk("s1_level_after_accept", o_level, 1);
    chk("s1_valid_early", o_flit_valid, 0);
    step();
    chk("s1_valid", o_flit_valid, 1);
    chk("s1_flit", o_flit, 38'h3A_0000_000A);
    chk("s1_sent", o_sent_count, 1);
    chk("s1_credits", dut.credits, 7);
    chk("s1_level_after_pop", o_level, 0);
    step();
    chk("s1_valid_pulse", o_flit_valid, 0);
    chk("s1_flit_hold", o_flit, 38'h3A_0000_000A);

    // Credit starvation: drain credits to 2, then push 4 back-to-back
    do_reset();
    for (int i = 0; i < 6; i++) begin
      i_data = fin(3'(i), 1'b0);
      i_data_valid = 1'b1;
      step();
    end
    i_data_valid = 1'b0;
    step();
    chk("s2_credits_2", dut.credits, 2);
    chk("s2_sent_6", o_sent_count, 6);
    chk("s2_level_0", o_level, 0);
    for (int i = 1; i <= 4; i++) begin
      i_data = fin(3'(i), 1'(i));
      i_data_valid = 1'b1;
      step();
    end
    i_data_valid = 1'b0;
    chk("s2_level_2", o_level, 2);
    chk("s2_ready", o_data_ready, 1);
    chk("s2_sent_8", o_sent_count, 8);
    step();
    chk("s2_starved_valid", o_flit_valid, 0);
    chk("s2_starved_sent", o_sent_count, 8);
    i_credit = 1'b1;
    step();
    chk("s2_credit_valid", o_flit_valid, 1);
    chk("s2_credit_flit", o_flit, fout(3'd3, 1'b1, 32'd9));
    chk("s2_credit_sent", o_sent_count, 9);
    chk("s2_credit_level", o_level, 1);
    chk("s2_credits_0", dut.credits, 0);

    // FIFO full with zero credits; fifth flit waits for ready
    i_credit = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      i_data = fin(3'(i), 1'b0);
      i_data_valid = 1'b1;
      step();
    end
    chk("s3_level_full", o_level, 4);
    chk("s3_ready_low", o_data_ready, 0);
    i_data = fin(3'd0, 1'b1);
    step();
    chk("s3_held_level", o_level, 4);
    chk("s3_held_valid", o_flit_valid, 0);
    i_credit = 1'b1;
    step();
    chk("s3_pop_flit", o_flit, fout(3'd4, 1'b0, 32'd10));
    chk("s3_pop_level", o_level, 3);
    chk("s3_ready_back", o_data_ready, 1);
    i_credit = 1'b0;
    step();
    i_data_valid = 1'b0;
    chk("s3_fifth_accepted", o_level, 4);
    chk("s3_no_send", o_flit_valid, 0);
    order_exp[0] = fout(3'd5, 1'b0, 32'd13);
    order_exp[1] = fout(3'd6, 1'b0, 32'd14);
    order_exp[2] = fout(3'd7, 1'b0, 32'd15);
    order_exp[3] = fout(3'd0, 1'b1, 32'd18);
    i_credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_order_valid", o_flit_valid, 1);
      chk("s3_order_flit", o_flit, order_exp[i]);
    end
    chk("s3_level_empty", o_level, 0);
    chk("s3_sent_14", o_sent_count, 14);
    chk("s3_err", o_credit_err, 0);

    // Mid-run reset discards queued flits
    i_credit = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i_data = fin(3'(i), 1'b0);
      i_data_valid = 1'b1;
      step();
    end
    chk("s6_queued", o_level, 3);
    i_data = fin(3'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_data_valid = 1'b0;
    #1;
    chk("s6_level", o_level, 0);
    chk("s6_valid", o_flit_valid, 0);
    chk("s6_sent", o_sent_count, 0);
    chk("s6_flit", o_flit, 0);
    chk("s6_credits", dut.credits, 8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s6_nothing_emerges", o_flit_valid, 0);
    end
    chk("s6_sent_still_0", o_sent_count, 0);

    // Steady stream with a credit every cycle
    do_reset();
    i_data = fin(3'd1, 1'b0);
    i_data_valid = 1'b1;
    step();
    i_credit = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      i_data = fin(3'(k), 1'b0);
      step();
      chk("s4_valid", o_flit_valid, 1);
      chk("s4_flit", o_flit, fout(3'(k - 1), 1'b0, 32'(k - 2)));
      chk("s4_level", o_level, 1);
      chk("s4_credits", dut.credits, 8);
      chk("s4_err", o_credit_err, 0);
    end
    i_data_valid = 1'b0;
    i_credit = 1'b0;
    step();
    chk("s4_last_flit", o_flit, fout(3'd7, 1'b0, 32'd6));
    chk("s4_credits_7", dut.credits, 7);
    chk("s4_sent", o_sent_count, 7);

    // Credit overflow
    i_credit = 1'b1;
    step();
    chk("s5_credits_full", dut.credits, 8);
    chk("s5_no_err_yet", o_credit_err, 0);
    step();
    chk("s5_err_set", o_credit_err, 1);
    chk("s5_credits_capped", dut.credits, 8);
    i_credit = 1'b0;
    step();
    chk("s5_err_sticky", o_credit_err, 1);
    do_reset();
    chk("s5_err_cleared", o_credit_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ni_inject.md
# ni_inject

Synthesizable network-interface injection stage between a processing element (PE) and its router's input port in the FT4 NoC. It accepts 38-bit flits from the PE on a valid/ready handshake and buffers them in a FIFO. It optionally stamps an injection timestamp into the payload, then forwards flits to the router under credit-based flow control. It also counts sent flits for end-of-run reporting.

## Interface
- FLIT_W, 38, flit width; layout {valid[37], tail[36], dest[35:33], vc[32], payload[31:0]}
- DEPTH, 4, FIFO entries; power of 2, ≥2
- CREDITS, 8, router input-buffer slots; initial credit count
- STAMP, 1, 1 = replace payload[31:0] with the cycle count at accept; 0 = pass payload unchanged

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_data  in  FLIT_W  flit from PE
- i_data_valid  in  1  PE flit valid
- o_data_ready  out  1  block can accept a flit this cycle
- o_flit  out  FLIT_W  flit to router
- o_flit_valid  out  1  o_flit valid; one-cycle pulse per flit
- i_credit  in  1  router returns one credit this cycle
- o_sent_count  out  32  flits sent since reset
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_credit_err  out  1  sticky: credit returned while counter already at CREDITS

## Operation
- Cycle counter: 32-bit, 0 at reset, +1 every cycle, wraps modulo 2^32.
- Accept: push when i_data_valid && o_data_ready.
  - Stored flit = i_data, with payload[31:0] replaced by the cycle-counter value on that edge when STAMP=1.
- o_data_ready = !rst && (level != DEPTH). Combinational from the registered level; it does not depend on i_data_valid.
- Send: at a clock edge where FIFO is non-empty and credits > 0:
  - pop the head into the output register;
  - o_flit_valid <= 1;
  - credits −1;
  - o_sent_count +1, wrapping modulo 2^32.
- Otherwise o_flit_valid <= 0 and o_flit holds its last value.
- Output forcing: o_flit[37] is forced to 1 and o_flit[32] (vc) to 0. Bits 36:33 pass unchanged.
- Credits: range 0..CREDITS.
  - i_credit alone: +1.
  - Pop alone: −1.
  - i_credit and pop in the same cycle: unchanged.
  - i_credit while at CREDITS with no pop: counter stays at CREDITS and o_credit_err sets, held until rst.
- Simultaneous push and pop: level unchanged, pointers advance independently.
- Push while full: impossible, because ready is low.
- Pop while empty: none.
- At most one flit is sent per cycle. Back-to-back sends occur while FIFO is non-empty and credits > 0.

## Timing
- Reset (one edge with rst=1) sets:
  - o_flit=0, o_flit_valid=0, o_sent_count=0, o_level=0, o_credit_err=0;
  - credits=CREDITS, pointers=0, cycle counter=0.
- o_data_ready is 0 while rst=1 and 1 in the first cycle after reset.
- Reset mid-operation discards all buffered flits and restores full credits. A flit presented in the reset cycle is not accepted.
- Latency:
  - flit accepted at edge t enters FIFO, o_level updates after t;
  - earliest pop is at edge t+1, so o_flit_valid is high in the cycle after edge t+1;
  - accept-to-output is 2 edges minimum.
- Credit latency: a credit returned at edge t can enable a pop at edge t if credits were 0 before that edge. The credit test uses credits + i_credit, not just the registered value.
- Full condition: level==DEPTH drops ready in the next cycle after the filling push. A pop at the same edge as the filling push keeps level < DEPTH.

## Test plan
- Reset then single flit: STAMP=1, flit {1,1,3'd5,0,32'hDEAD_BEEF} accepted at cycle 10 -> one-cycle o_flit_valid after edge 11; o_flit={1,1,5,0,32'd10}; o_sent_count=1; credits=7.
- Credit starvation: CREDITS=2, no i_credit, push 4 flits back-to-back -> exactly 2 sent, o_level=2, o_data_ready=1. Then one i_credit pulse -> exactly one more flit sent on that edge.
- FIFO full: credits held at 0, push 5 flits with DEPTH=4 -> o_data_ready=0 after the 4th accept, 5th flit held by PE. Return 1 credit -> 5th accepted 2 edges later, order preserved.
- Simultaneous push/pop/credit: steady stream with i_credit every cycle -> one flit out per cycle; o_level and credits constant; o_credit_err stays 0.
- Credit overflow: idle with credits=8, pulse i_credit -> o_credit_err=1 and persists; credits stay 8. rst clears it.
- Mid-run reset: 3 flits queued, rst for one edge -> o_level=0, o_flit_valid=0, o_sent_count=0. Queued flits never emerge.
